// File: rtl/multiport_regfile.sv
// Multi-read, dual-write register file with per-entry pending bits and a
// sweeping soft clear; reads are combinational with optional write bypass.
module multiport_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_req,
    output logic                    ready,
    input  logic [NRD*ADDR_W-1:0]   raddr,
    output logic [NRD*DATA_W-1:0]   rdata,
    output logic [NRD-1:0]          rpend,
    input  logic                    we0,
    input  logic [ADDR_W-1:0]       waddr0,
    input  logic [DATA_W-1:0]       wdata0,
    input  logic                    we1,
    input  logic [ADDR_W-1:0]       waddr1,
    input  logic [DATA_W-1:0]       wdata1,
    input  logic                    mark_en,
    input  logic [ADDR_W-1:0]       mark_addr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     clr_idx_q, clr_idx_d;
    logic [ADDR_W:0]     clr_idx_inc;
    logic [ADDR_W-1:0]   clr_addr;
    logic [DEPTH-1:0]    pend_q, pend_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Requests qualified only by the zero-register rule; state gating is applied where used.
    logic wr0_ok, wr1_ok, mark_ok;

    assign wr0_ok   = we0     && !(ZR && (waddr0    == '0));
    assign wr1_ok   = we1     && !(ZR && (waddr1    == '0));
    assign mark_ok  = mark_en && !(ZR && (mark_addr == '0));
    assign clr_addr = clr_idx_q[ADDR_W-1:0];
    assign ready    = (state_q == ST_IDLE);

    // The extra counter bit flags the terminal count once the last entry is swept.
    assign clr_idx_inc = clr_idx_q + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_inc;
                if (clr_idx_inc[ADDR_W]) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = '0;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        if (state_q == ST_CLEAR) begin
            pend_d[clr_addr] = 1'b0;
        end else begin
            if (wr0_ok) pend_d[waddr0] = 1'b0;
            if (wr1_ok) pend_d[waddr1] = 1'b0;
            if (mark_ok) pend_d[mark_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            pend_q    <= pend_d;
        end
    end

    // Port 1 is written last so it wins when both ports target one entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_addr] <= '0;
            end else begin
                if (wr0_ok) mem_q[waddr0] <= wdata0;
                if (wr1_ok) mem_q[waddr1] <= wdata1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rd;
            logic              rp;
            logic              hit0, hit1, mhit;

            assign ra = raddr[gi*ADDR_W +: ADDR_W];

            always_comb begin
                hit0 = BP && wr0_ok && (waddr0 == ra);
                hit1 = BP && wr1_ok && (waddr1 == ra);
                mhit = mark_ok && (mark_addr == ra);
                rd   = mem_q[ra];
                rp   = pend_q[ra];
                if (hit1) begin
                    rd = wdata1;
                    rp = mhit;
                end else if (hit0) begin
                    rd = wdata0;
                    rp = mhit;
                end
                if ((state_q != ST_IDLE) || (ZR && (ra == '0))) begin
                    rd = '0;
                    rp = 1'b0;
                end
            end

            assign rdata[gi*DATA_W +: DATA_W] = rd;
            assign rpend[gi]                  = rp;
        end
    endgenerate

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NRD, default 2, number of read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, when 1 entry 0 reads as zero and ignores writes and marks.
REQ-005 Parameter BYPASS, default 1, when 1 same-cycle write data is forwarded to matching read ports.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 clr_req  in  1  soft-clear request, single-cycle pulse.
REQ-009 ready  out  1  high when the array is usable (no clear in progress).
REQ-010 raddr  in  NRD*ADDR_W  read addresses; port k in bits [k*ADDR_W +: ADDR_W].
REQ-011 rdata  out  NRD*DATA_W  read data, combinational; port k in bits [k*DATA_W +: DATA_W].
REQ-012 rpend  out  NRD  per-port pending flag of the addressed entry.
REQ-013 we0, waddr0, wdata0  in  1/ADDR_W/DATA_W  write port 0.
REQ-014 we1, waddr1, wdata1  in  1/ADDR_W/DATA_W  write port 1 (higher priority).
REQ-015 mark_en, mark_addr  in  1/ADDR_W  set pending bit of mark_addr (producer issued).

Function
REQ-016 FSM states: CLEAR, IDLE; ready = 1 only in IDLE.
REQ-017 CLEAR: counter clr_idx walks 0..DEPTH-1, writing zero and clearing pending of entry clr_idx each cycle; after DEPTH-1 is written, go to IDLE next cycle.
REQ-018 A clear therefore takes exactly DEPTH cycles; ready rises on the cycle after the last entry is cleared.
REQ-019 clr_req in IDLE enters CLEAR with clr_idx = 0 next cycle; clr_req during CLEAR is ignored (no restart).
REQ-020 During CLEAR: we0, we1 and mark_en are ignored; rdata = 0, rpend = 0 on all ports.
REQ-021 IDLE writes: weN with waddrN stores wdataN at the edge; if both ports target the same address, port 1 data is stored.
REQ-022 Write to an entry clears its pending bit; a mark_en to the same address in the same cycle takes precedence (bit ends set).
REQ-023 Read: rdata port k = entry[raddr k]; if BYPASS = 1 and a write targets raddr k this cycle, return that write's data (port 1 over port 0).
REQ-024 rpend port k = pending[raddr k]; with BYPASS = 1 a same-cycle write to that address forces 0 unless mark_en hits it too.
REQ-025 ZERO_REG = 1: address 0 always reads 0 with rpend 0; writes and marks to 0 have no effect; bypass does not apply to address 0.
REQ-026 All read ports are independent; identical addresses on several ports return identical data.
REQ-027 No arithmetic beyond clr_idx increment; clr_idx is ADDR_W+1 bits wide so the terminal count is detected without wrap.

Reset
REQ-028 rst high at an edge forces state CLEAR, clr_idx = 0 and all pending bits 0; rst overrides clr_req, writes and marks in that cycle.
REQ-029 After rst deasserts, ready is 0 for DEPTH cycles, then 1; all entries read 0.
REQ-030 rst asserted mid-clear restarts the clear from entry 0.

Verification
REQ-031 rst 1 cycle, default params -> ready 0 for 32 cycles then 1; every address reads 0, rpend 0.
REQ-032 IDLE: we0 addr 5 data 0xDEADBEEF, raddr0 = 5 same cycle -> rdata0 = 0xDEADBEEF (bypass); next cycle still 0xDEADBEEF.
REQ-033 we0 and we1 both addr 7, data 0x11 / 0x22 -> entry 7 reads 0x22 afterwards.
REQ-034 mark_en addr 9 -> rpend 1 next cycle; then we1 addr 9 data 0x55 -> rpend 0, rdata 0x55; mark+write same cycle addr 9 -> rpend 1.
REQ-035 we0 addr 0 data 0xFFFFFFFF, mark_en addr 0 -> address 0 reads 0, rpend 0.
REQ-036 Populate entries, pulse clr_req, write during clear, pulse rst at clear cycle 10 -> writes lost, clear restarts, ready returns 32 cycles after rst, all entries 0.
